// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings and FSM states.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane logic: extracts/extends sub-word loads and merges sub-word
// store data into the old memory word. Purely combinational.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = old_word_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? old_word_i[31:16] : old_word_i[15:0];

    case (size_i)
      SZ_BYTE: load_data_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
      SZ_HALF: load_data_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
      default: load_data_o = old_word_i;
    endcase
  end

  // Only the addressed lane changes; every other byte keeps the old contents.
  always_comb begin
    store_word_o = old_word_i;
    case (size_i)
      SZ_BYTE: store_word_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
      SZ_HALF: begin
        if (offset_i[1]) store_word_o[31:16] = wdata_i[15:0];
        else             store_word_o[15:0]  = wdata_i[15:0];
      end
      default: store_word_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store stage in front of a word-only memory; sub-word
// stores are read-modify-write, misaligned or illegal requests return an error.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter bit MISALIGN_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_read_data,
  output logic [31:0]       mem_write_data,
  output logic              mem_write_enable
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              unsigned_q, write_q, err_q;
  logic [31:0]       wdata_q, old_q;

  logic              accept, req_err, misalign;
  logic [ADDR_W-1:0] addr_in;
  logic [31:0]       load_data, store_word;

  assign accept = req_valid && (state_q == IDLE);

  always_comb begin
    misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
               ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    req_err  = (req_size == 2'd3) || (MISALIGN_CHECK && misalign);
    addr_in  = req_addr;
    // Without the check, misaligned accesses proceed at the aligned-down address.
    if (!MISALIGN_CHECK) begin
      if (req_size == SZ_HALF) addr_in[0]   = 1'b0;
      if (req_size == SZ_WORD) addr_in[1:0] = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (req_valid) begin
        if (req_err)                   state_d = RESP;
        else if (!req_write)           state_d = RD;
        else if (req_size == SZ_WORD)  state_d = WR;
        else                           state_d = RD;
      end
      RD:      state_d = write_q ? WR : RESP;
      WR:      state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      size_q     <= SZ_BYTE;
      unsigned_q <= 1'b0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      wdata_q    <= '0;
      old_q      <= '0;
    end else begin
      if (accept) begin
        addr_q     <= addr_in;
        size_q     <= req_size;
        unsigned_q <= req_unsigned;
        write_q    <= req_write;
        err_q      <= req_err;
        wdata_q    <= req_wdata;
      end
      if (state_q == RD) old_q <= mem_read_data;
    end
  end

  lsu_lane_align u_align (
    .old_word_i   (old_q),
    .offset_i     (addr_q[1:0]),
    .size_i       (size_q),
    .unsigned_i   (unsigned_q),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .store_word_o (store_word)
  );

  always_comb begin
    req_ready        = (state_q == IDLE);
    resp_valid       = (state_q == RESP);
    resp_error       = (state_q == RESP) && err_q;
    resp_rdata       = ((state_q == RESP) && !err_q && !write_q) ? load_data : 32'h0;
    mem_addr         = '0;
    mem_write_data   = 32'h0;
    mem_write_enable = (state_q == WR) && !reset;
    if ((state_q == RD) || (state_q == WR)) mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
    if (state_q == WR) mem_write_data = store_word;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a 16-word behavioural memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_read_data, mem_write_data;
  logic        mem_write_enable;

  logic [31:0] mem [0:15];
  int          wr_total;
  int          n_chk, n_err;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .MISALIGN_CHECK(1'b1)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_unsigned     (req_unsigned),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_error       (resp_error),
    .mem_addr         (mem_addr),
    .mem_read_data    (mem_read_data),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable)
  );

  assign mem_read_data = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (mem_write_enable) begin
      mem[mem_addr[5:2]] <= mem_write_data;
      wr_total           <= wr_total + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Issues one request; lat is the cycle (1 = first cycle after the accept edge)
  // in which resp_valid is seen, we_cyc the last cycle with the write strobe high.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int we_cyc, output int we_cnt,
                        output logic [31:0] wa, output logic [31:0] wdat);
    lat = 99; rd = '0; er = 1'b0; we_cyc = 0; we_cnt = 0; wa = '0; wdat = '0;
    @(negedge clk);
    chk("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_write_enable) begin
        we_cnt++; we_cyc = k; wa = mem_addr; wdat = mem_write_data;
      end
      if (resp_valid) begin
        lat = k; rd = resp_rdata; er = resp_error;
        break;
      end
    end
    @(negedge clk);
    chk("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
  endtask

  int          lat, we_cyc, we_cnt, wr_before;
  logic [31:0] rd, wa, wdat;
  logic        er;

  typedef struct {
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t loads [6] = '{
    '{2'd0, 1'b0, 32'd15, 32'hFFFF_FF80},
    '{2'd0, 1'b1, 32'd15, 32'h0000_0080},
    '{2'd1, 1'b0, 32'd12, 32'h0000_1234},
    '{2'd1, 1'b0, 32'd14, 32'hFFFF_80FF},
    '{2'd2, 1'b1, 32'd12, 32'h80FF_1234},
    '{2'd0, 1'b0, 32'd13, 32'h0000_0012}
  };

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] addr;
  } err_vec_t;

  err_vec_t errs [4] = '{
    '{1'b0, 2'd1, 32'd13},
    '{1'b1, 2'd2, 32'd6},
    '{1'b0, 2'd3, 32'd0},
    '{1'b1, 2'd1, 32'd15}
  };

  initial begin
    n_chk = 0; n_err = 0; wr_total = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[3] = 32'h80FF_1234;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready",  {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_error", {31'd0, resp_error}, 32'd0);
    chk("rst_mem_we",     {31'd0, mem_write_enable}, 32'd0);
    chk("rst_mem_addr",   mem_addr, 32'd0);
    chk("rst_mem_wdata",  mem_write_data, 32'd0);
    reset = 1'b0;

    foreach (loads[i]) begin
      do_req(1'b0, loads[i].sz, loads[i].uns, loads[i].addr, 32'h0,
             lat, rd, er, we_cyc, we_cnt, wa, wdat);
      chk("load_rdata", rd, loads[i].exp);
      chk("load_latency", lat, 32'd2);
      chk("load_error", {31'd0, er}, 32'd0);
      chk("load_no_write", we_cnt, 32'd0);
    end

    wr_before = wr_total;
    do_req(1'b1, 2'd0, 1'b0, 32'd13, 32'hFFFF_FFAB, lat, rd, er, we_cyc, we_cnt, wa, wdat);
    chk("sb_latency", lat, 32'd3);
    chk("sb_we_count", we_cnt, 32'd1);
    chk("sb_we_cycle", we_cyc, 32'd2);
    chk("sb_mem_addr", wa, 32'd12);
    chk("sb_mem_data", wdat, 32'h80FF_AB34);
    chk("sb_mem_word", mem[3], 32'h80FF_AB34);
    chk("sb_total_writes", wr_total - wr_before, 32'd1);

    do_req(1'b1, 2'd1, 1'b0, 32'd14, 32'h1234_5566, lat, rd, er, we_cyc, we_cnt, wa, wdat);
    chk("sh_latency", lat, 32'd3);
    chk("sh_mem_data", wdat, 32'h5566_AB34);

    do_req(1'b0, 2'd0, 1'b1, 32'd13, 32'h0, lat, rd, er, we_cyc, we_cnt, wa, wdat);
    chk("lbu_after_merge", rd, 32'h0000_00AB);

    wr_before = wr_total;
    do_req(1'b1, 2'd2, 1'b0, 32'd8, 32'hDEAD_BEEF, lat, rd, er, we_cyc, we_cnt, wa, wdat);
    chk("sw_latency", lat, 32'd2);
    chk("sw_we_count", we_cnt, 32'd1);
    chk("sw_we_cycle", we_cyc, 32'd1);
    chk("sw_mem_addr", wa, 32'd8);
    chk("sw_mem_data", wdat, 32'hDEAD_BEEF);
    chk("sw_mem_word", mem[2], 32'hDEAD_BEEF);
    chk("sw_total_writes", wr_total - wr_before, 32'd1);

    wr_before = wr_total;
    foreach (errs[i]) begin
      do_req(errs[i].wr, errs[i].sz, 1'b0, errs[i].addr, 32'hFFFF_FFFF,
             lat, rd, er, we_cyc, we_cnt, wa, wdat);
      chk("err_latency", lat, 32'd1);
      chk("err_flag", {31'd0, er}, 32'd1);
      chk("err_rdata", rd, 32'd0);
      chk("err_no_we", we_cnt, 32'd0);
    end
    chk("err_total_writes", wr_total - wr_before, 32'd0);

    // Abort a byte store with reset during its write cycle.
    wr_before = wr_total;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd12; req_wdata = 32'h0000_0077;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_wr", {31'd0, mem_write_enable}, 32'd1);
    reset = 1'b1;
    #1 chk("abort_we_masked", {31'd0, mem_write_enable}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("abort_no_resp_late", {31'd0, resp_valid}, 32'd0);
    chk("abort_no_write", wr_total - wr_before, 32'd0);
    chk("abort_mem_word", mem[3], 32'h5566_AB34);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
